// File: rtl/updown_counter_oneshot_n.sv
// One-shot up/down event counter with wrap/saturate bounds, synchronous load and status flags.
// Optional 2-flop input synchroniser on up_in/down_in enabled by defining UPDOWN_SYNC_EN.
module updown_counter_oneshot_n #(
    parameter int WIDTH     = 3,
    parameter int MAX_COUNT = 2**WIDTH-1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             up_in,
    input  logic             down_in,
    input  logic             wrap_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] C_MAX  = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic             r_wrapped;
    logic             r_up_prev;
    logic             r_dn_prev;
    logic             w_up_s;
    logic             w_dn_s;
    logic             w_up_edge;
    logic             w_dn_edge;

`ifdef UPDOWN_SYNC_EN
    logic [1:0] r_up_sync;
    logic [1:0] r_dn_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_up_sync <= 2'b00;
            r_dn_sync <= 2'b00;
        end else begin
            r_up_sync <= {r_up_sync[0], up_in};
            r_dn_sync <= {r_dn_sync[0], down_in};
        end
    end

    assign w_up_s = r_up_sync[1];
    assign w_dn_s = r_dn_sync[1];
`else
    assign w_up_s = up_in;
    assign w_dn_s = down_in;
`endif

    assign w_up_edge = w_up_s & ~r_up_prev;
    assign w_dn_edge = w_dn_s & ~r_dn_prev;

    // prev tracks the sample every cycle, so edges swallowed by a load are not replayed later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count   <= C_ZERO;
            r_wrapped <= 1'b0;
            r_up_prev <= 1'b0;
            r_dn_prev <= 1'b0;
        end else begin
            r_up_prev <= w_up_s;
            r_dn_prev <= w_dn_s;
            r_wrapped <= 1'b0;
            if (load) begin
                r_count <= (load_value > C_MAX) ? C_MAX : load_value;
            end else if (w_up_edge && !w_dn_edge) begin
                if (r_count < C_MAX) begin
                    r_count <= r_count + C_ONE;
                end else if (wrap_mode) begin
                    r_count   <= C_ZERO;
                    r_wrapped <= 1'b1;
                end
            end else if (w_dn_edge && !w_up_edge) begin
                if (r_count > C_ZERO) begin
                    r_count <= r_count - C_ONE;
                end else if (wrap_mode) begin
                    r_count   <= C_MAX;
                    r_wrapped <= 1'b1;
                end
            end
        end
    end

    assign count   = r_count;
    assign wrapped = r_wrapped;
    assign at_max  = (r_count == C_MAX);
    assign at_min  = (r_count == C_ZERO);

endmodule

// File: tb/tb_updown_counter_oneshot_n.sv
// Directed bench for updown_counter_oneshot_n: a MAX_COUNT=7 instance and a MAX_COUNT=5 instance on shared stimulus.
module tb_updown_counter_oneshot_n;

`ifdef UPDOWN_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       up_in = 1'b0;
    logic       down_in = 1'b0;
    logic       wrap_mode = 1'b1;
    logic       load = 1'b0;
    logic [2:0] load_value = 3'd0;
    logic [2:0] count7, count5;
    logic       at_max7, at_min7, wrapped7;
    logic       at_max5, at_min5, wrapped5;

    int checks = 0;
    int failures = 0;

    updown_counter_oneshot_n #(.WIDTH(3), .MAX_COUNT(7)) dut7 (
        .clk(clk), .reset_n(reset_n), .up_in(up_in), .down_in(down_in),
        .wrap_mode(wrap_mode), .load(load), .load_value(load_value),
        .count(count7), .at_max(at_max7), .at_min(at_min7), .wrapped(wrapped7)
    );

    updown_counter_oneshot_n #(.WIDTH(3), .MAX_COUNT(5)) dut5 (
        .clk(clk), .reset_n(reset_n), .up_in(up_in), .down_in(down_in),
        .wrap_mode(wrap_mode), .load(load), .load_value(load_value),
        .count(count5), .at_max(at_max5), .at_min(at_min5), .wrapped(wrapped5)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst;
        bit up;
        bit dn;
        bit wm;
        bit ld;
        int lv;
        int ec;
        bit ew;
    } vec_t;

    vec_t vecs[29];

    function automatic vec_t mk(bit rst, bit up, bit dn, bit wm, bit ld, int lv, int ec, bit ew);
        vec_t v;
        v.rst = rst; v.up = up; v.dn = dn; v.wm = wm;
        v.ld = ld; v.lv = lv; v.ec = ec; v.ew = ew;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        up_in = 1'b0; down_in = 1'b0; load = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One-cycle stimulus, then inputs return low; sampled once the edge has propagated.
    task automatic pulse(input bit up, input bit dn, input bit wm, input bit ld, input int lv);
        @(negedge clk);
        up_in = up; down_in = dn; wrap_mode = wm; load = ld; load_value = 3'(lv);
        @(negedge clk);
        up_in = 1'b0; down_in = 1'b0; load = 1'b0;
        repeat (LAT) @(negedge clk);
    endtask

    task automatic chk7(input string name, input int ec, input bit ew);
        chk({name, " count"}, int'(count7), ec);
        chk({name, " wrapped"}, int'(wrapped7), int'(ew));
        chk({name, " at_max"}, int'(at_max7), (ec == 7) ? 1 : 0);
        chk({name, " at_min"}, int'(at_min7), (ec == 0) ? 1 : 0);
    endtask

    task automatic chk5(input string name, input int ec, input bit ew);
        chk({name, " count5"}, int'(count5), ec);
        chk({name, " wrapped5"}, int'(wrapped5), int'(ew));
        chk({name, " at_max5"}, int'(at_max5), (ec == 5) ? 1 : 0);
        chk({name, " at_min5"}, int'(at_min5), (ec == 0) ? 1 : 0);
    endtask

    initial begin
        for (int i = 0; i < 9; i++)
            vecs[i] = mk(0, 1, 0, 1, 0, 0, (i + 1) % 8, (i == 7));
        vecs[9]  = mk(1, 0, 1, 0, 0, 0, 0, 0);
        vecs[10] = mk(0, 0, 1, 0, 0, 0, 0, 0);
        vecs[11] = mk(0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            vecs[12 + i] = mk(0, 1, 0, 0, 0, 0, (i < 7) ? i + 1 : 7, 0);
        vecs[22] = mk(0, 0, 0, 0, 1, 3, 3, 0);
        vecs[23] = mk(0, 1, 1, 1, 0, 0, 3, 0);
        vecs[24] = mk(0, 0, 1, 1, 0, 0, 2, 0);
        vecs[25] = mk(0, 0, 0, 1, 1, 0, 0, 0);
        vecs[26] = mk(0, 0, 1, 1, 0, 0, 7, 1);
        vecs[27] = mk(0, 1, 0, 0, 0, 0, 7, 0);
        vecs[28] = mk(0, 0, 0, 0, 1, 6, 6, 0);

        #2;
        chk7("reset", 0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 29; i++) begin
            if (vecs[i].rst) do_reset();
            pulse(vecs[i].up, vecs[i].dn, vecs[i].wm, vecs[i].ld, vecs[i].lv);
            chk7($sformatf("vec%0d", i), vecs[i].ec, vecs[i].ew);
        end

        // Load wins over simultaneous up/down edges.
        pulse(0, 0, 1, 1, 3);
        chk7("preload3", 3, 0);
        pulse(1, 1, 1, 1, 6);
        chk7("load_vs_edges", 6, 0);
        repeat (4) @(negedge clk);
        chk7("load_vs_edges_settled", 6, 0);

        // Asynchronous reset between clocks, then an input held high across release.
        pulse(0, 0, 1, 1, 4);
        chk7("preload4", 4, 0);
        #2 reset_n = 1'b0;
        #1 chk7("async_reset", 0, 0);
        up_in = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (LAT + 1) @(negedge clk);
        chk7("held_across_release", 1, 0);
        repeat (5) @(negedge clk);
        chk7("held_across_release_hold", 1, 0);
        up_in = 1'b0;

        // Step latency: visible at the first sample point only in the direct build.
        do_reset();
        @(negedge clk);
        up_in = 1'b1; wrap_mode = 1'b1;
        @(negedge clk);
        up_in = 1'b0;
        chk("latency_edge0", int'(count7), (LAT == 0) ? 1 : 0);
        repeat (LAT) @(negedge clk);
        chk("latency_final", int'(count7), 1);

        // Toggling every cycle for 8 cycles gives 4 rising edges.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            up_in = (i % 2 == 0);
        end
        @(negedge clk);
        up_in = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        chk7("toggle8", 4, 0);

        // MAX_COUNT=5 instance: wrap both ways, clamped load, long hold.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pulse(1, 0, 1, 0, 0);
            chk5($sformatf("m5_up%0d", i), i + 1, 0);
        end
        pulse(1, 0, 1, 0, 0);
        chk5("m5_wrap_up", 0, 1);
        pulse(0, 1, 1, 0, 0);
        chk5("m5_wrap_down", 5, 1);
        pulse(0, 0, 1, 1, 2);
        chk5("m5_load2", 2, 0);
        pulse(0, 0, 1, 1, 7);
        chk5("m5_load7_clamped", 5, 0);
        pulse(0, 0, 1, 1, 2);
        @(negedge clk);
        up_in = 1'b1;
        repeat (20) @(negedge clk);
        chk5("m5_held20", 3, 0);
        up_in = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        chk5("m5_held20_release", 3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
